// File: rtl/alu_seq_ctrl.sv
// Moore sequencer for the register-file / A-B-C / ALU datapath.
// One instruction per accepted start pulse, then back to idle.
module alu_seq_ctrl #(
  parameter logic [2:0] OP_MOV = 3'b110,
  parameter logic [2:0] OP_ALU = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [1:0] alu_op,
  output logic [2:0] nsel,
  output logic       vsel,
  output logic       asel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       err
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_ALU,
    S_CMP,
    S_WREG
  } state_t;

  state_t     state_q, state_d;
  logic       err_q, err_d;
  logic       mov_q, mov_d;
  logic       alu_q, alu_d;
  logic [1:0] op_q, op_d;

  logic accept;
  logic is_imm, is_mreg, is_mvn, is_arith, is_cmp;

  assign accept = (state_q == S_WAIT) && s;

  // Instruction class is captured at accept so every strobe
  // depends only on registered state.
  assign is_imm   = mov_q && (op_q == 2'b10);
  assign is_mreg  = mov_q && (op_q == 2'b00);
  assign is_mvn   = alu_q && (op_q == 2'b11);
  assign is_arith = alu_q && (op_q != 2'b11);
  assign is_cmp   = alu_q && (op_q == 2'b01);

  always_comb begin
    mov_d = mov_q;
    alu_d = alu_q;
    op_d  = op_q;
    if (accept) begin
      mov_d = (opcode == OP_MOV);
      alu_d = (opcode == OP_ALU);
      op_d  = op;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d = S_DECODE;
          err_d   = 1'b0;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_imm:   state_d = S_WIMM;
          is_mreg:  state_d = S_GETB;
          is_mvn:   state_d = S_GETB;
          is_arith: state_d = S_GETA;
          default: begin
            state_d = S_WAIT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_WIMM:  state_d = S_WAIT;
      S_GETA:  state_d = S_GETB;
      S_GETB:  state_d = is_cmp ? S_CMP : S_ALU;
      S_ALU:   state_d = S_WREG;
      S_CMP:   state_d = S_WAIT;
      S_WREG:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_WAIT;
      err_q   <= 1'b0;
      mov_q   <= 1'b0;
      alu_q   <= 1'b0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      mov_q   <= mov_d;
      alu_q   <= alu_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    w      = 1'b0;
    alu_op = 2'b00;
    nsel   = 3'b000;
    vsel   = 1'b0;
    asel   = 1'b0;
    loada  = 1'b0;
    loadb  = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    write  = 1'b0;
    unique case (state_q)
      S_WAIT: w = 1'b1;
      S_WIMM: begin
        nsel  = 3'b100;
        vsel  = 1'b1;
        write = 1'b1;
      end
      S_GETA: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc  = 1'b1;
        alu_op = mov_q ? 2'b00 : op_q;
        asel   = mov_q || (op_q == 2'b11);
      end
      S_CMP: begin
        alu_op = 2'b01;
        loads  = 1'b1;
      end
      S_WREG: begin
        nsel  = 3'b010;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  assign err = err_q;

  strobe_onehot: assert property (@(posedge clk)
    $onehot0({write, loada, loadb, loadc, loads}));

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: per-cycle output traces
// for each instruction class plus reset and back-to-back cases.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, vsel, asel, loada, loadb, loadc, loads, write, err;
  logic [1:0] alu_op;
  logic [2:0] nsel;

  int n_chk = 0;
  int n_fail = 0;

  alu_seq_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .s      (s),
    .opcode (opcode),
    .op     (op),
    .w      (w),
    .alu_op (alu_op),
    .nsel   (nsel),
    .vsel   (vsel),
    .asel   (asel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .write  (write),
    .err    (err)
  );

  always #5 clk = ~clk;

  // {w, err, alu_op, nsel, vsel, asel, loada, loadb, loadc, loads, write}
  logic [13:0] obs;
  assign obs = {w, err, alu_op, nsel, vsel, asel,
                loada, loadb, loadc, loads, write};

  localparam logic [13:0] IDLE = 14'b1_0_00_000_0_0_00000;
  localparam logic [13:0] IDLE_ERR = 14'b1_1_00_000_0_0_00000;
  localparam logic [13:0] QUIET = 14'b0;

  // Cycle indices count from 1 = first cycle after the accept edge;
  // 0 means the event never happens in that instruction.
  typedef struct {
    string      name;
    logic [2:0] opc;
    logic [1:0] op;
    int         lat;
    int         la;
    int         lb;
    int         ex;
    bit         ex_s;
    logic [1:0] aop;
    bit         asl;
    int         wr;
    logic [2:0] wn;
    bit         wv;
    bit         err;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mk(string nm, logic [2:0] oc, logic [1:0] o,
                              int lat, int la, int lb, int ex, bit exs,
                              logic [1:0] aop, bit asl, int wr,
                              logic [2:0] wn, bit wv, bit e);
    vec_t v;
    v.name = nm; v.opc = oc; v.op = o; v.lat = lat;
    v.la = la; v.lb = lb; v.ex = ex; v.ex_s = exs;
    v.aop = aop; v.asl = asl; v.wr = wr; v.wn = wn;
    v.wv = wv; v.err = e;
    return v;
  endfunction

  function automatic logic [13:0] expo(vec_t v, int k);
    logic       ew, ee, eas, evs, ela, elb, elc, els, ewr;
    logic [1:0] eao;
    logic [2:0] ens;
    ew  = (k == v.lat);
    ee  = ew && v.err;
    ela = (k == v.la);
    elb = (k == v.lb);
    elc = (k == v.ex) && !v.ex_s;
    els = (k == v.ex) && v.ex_s;
    ewr = (k == v.wr);
    eao = (k == v.ex) ? v.aop : 2'b00;
    eas = (k == v.ex) && v.asl;
    evs = ewr && v.wv;
    ens = ela ? 3'b100 : elb ? 3'b001 : ewr ? v.wn : 3'b000;
    return {ew, ee, eao, ens, evs, eas, ela, elb, elc, els, ewr};
  endfunction

  task automatic chk(string nm, int k, logic [13:0] got,
                     logic [13:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc%0d got=%b want=%b", nm, k, got, exp);
    end
  endtask

  // Called at #1 after the accept edge; checks cycles 1..upto.
  task automatic trace(vec_t v, int upto);
    for (int k = 1; k <= upto; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      chk(v.name, k, obs, expo(v, k));
    end
  endtask

  task automatic start(vec_t v);
    @(negedge clk);
    opcode = v.opc;
    op     = v.op;
    s      = 1'b1;
    @(posedge clk);
    #1;
    s = 1'b0;
  endtask

  vec_t mi, add;

  initial begin
    tv[0]  = mk("mov_imm", 3'b110, 2'b10, 3, 0, 0, 0, 0, 2'b00, 0,
                2, 3'b100, 1, 0);
    tv[1]  = mk("mov_reg", 3'b110, 2'b00, 5, 0, 2, 3, 0, 2'b00, 1,
                4, 3'b010, 0, 0);
    tv[2]  = mk("add", 3'b101, 2'b00, 6, 2, 3, 4, 0, 2'b00, 0,
                5, 3'b010, 0, 0);
    tv[3]  = mk("cmp", 3'b101, 2'b01, 5, 2, 3, 4, 1, 2'b01, 0,
                0, 3'b000, 0, 0);
    tv[4]  = mk("and", 3'b101, 2'b10, 6, 2, 3, 4, 0, 2'b10, 0,
                5, 3'b010, 0, 0);
    tv[5]  = mk("mvn", 3'b101, 2'b11, 5, 0, 2, 3, 0, 2'b11, 1,
                4, 3'b010, 0, 0);
    tv[6]  = mk("ill_011", 3'b011, 2'b00, 2, 0, 0, 0, 0, 2'b00, 0,
                0, 3'b000, 0, 1);
    tv[7]  = mk("add_clr", 3'b101, 2'b00, 6, 2, 3, 4, 0, 2'b00, 0,
                5, 3'b010, 0, 0);
    tv[8]  = mk("ill_mov01", 3'b110, 2'b01, 2, 0, 0, 0, 0, 2'b00, 0,
                0, 3'b000, 0, 1);
    tv[9]  = mk("mvn_clr", 3'b101, 2'b11, 5, 0, 2, 3, 0, 2'b11, 1,
                4, 3'b010, 0, 0);
    tv[10] = mk("ill_mov11", 3'b110, 2'b11, 2, 0, 0, 0, 0, 2'b00, 0,
                0, 3'b000, 0, 1);
    tv[11] = mk("mov_imm2", 3'b110, 2'b10, 3, 0, 0, 0, 0, 2'b00, 0,
                2, 3'b100, 1, 0);
    mi  = tv[0];
    add = tv[2];

    // Reset held with s=1: stays idle, no strobes.
    reset  = 1'b0;
    s      = 1'b1;
    opcode = 3'b110;
    op     = 2'b10;
    @(posedge clk);
    #1;
    chk("reset", 1, obs, IDLE);
    @(posedge clk);
    #1;
    chk("reset", 2, obs, IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    s = 1'b0;
    trace(mi, mi.lat);

    foreach (tv[i]) begin
      start(tv[i]);
      trace(tv[i], tv[i].lat);
    end

    // s held high: second instruction begins with no idle bubble.
    start(mi);
    s = 1'b1;
    trace(mi, mi.lat);
    opcode = add.opc;
    op     = add.op;
    @(posedge clk);
    #1;
    s = 1'b0;
    trace(add, add.lat);

    // Reset during the ALU cycle of an ADD cancels the write-back.
    start(add);
    trace(add, 4);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_alu", 5, obs, IDLE);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_alu", 6, obs, IDLE);

    // Illegal leaves err set while idle and ignores s=0.
    start(tv[6]);
    trace(tv[6], tv[6].lat);
    @(posedge clk);
    #1;
    chk("err_hold", 1, obs, IDLE_ERR);
    start(mi);
    chk("err_clear", 1, obs, QUIET);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("err_clear", 3, obs, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
